// File: rtl/subband_frame_serializer_if.sv
// Valid/ready stream carrying one scaled subband sample per transfer.
interface subband_frame_serializer_if #(
  parameter int OUT_W   = 16,
  parameter int FRAME_W = 8
);
  logic [OUT_W-1:0]   out_data;
  logic [3:0]         out_band;
  logic [FRAME_W-1:0] out_frame;
  logic               out_last;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output out_data, out_band, out_frame, out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_band, out_frame, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/subband_frame_serializer.sv
// Captures a frame of filterbank outputs on each decimation strobe, rounds and
// saturates every band, and streams the bands out over valid/ready through a
// two-slot ping-pong buffer. Frames arriving with both slots full are dropped
// and counted.
module subband_frame_serializer #(
  parameter int NUM_BANDS = 16,
  parameter int IN_W      = 25,
  parameter int OUT_W     = 16,
  parameter int SHIFT     = 9,
  parameter int FRAME_W   = 8
) (
  input  logic                      clk_en,
  input  logic                      reset,
  input  logic                      capture_strobe,
  input  logic [NUM_BANDS*IN_W-1:0] band_in,
  subband_frame_serializer_if.master out_if,
  output logic                      overrun,
  input  logic                      overrun_clr,
  output logic [FRAME_W-1:0]        drop_cnt
);

  localparam logic [0:0] ST_EMPTY  = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam logic [3:0]            LAST_BAND = 4'(NUM_BANDS - 1);
  localparam logic signed [IN_W:0]  RND       = (IN_W+1)'((1 << SHIFT) >> 1);
  localparam logic signed [IN_W:0]  SAT_MAX   = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0]  SAT_MIN   = (IN_W+1)'(-(1 << (OUT_W-1)));

  logic [OUT_W-1:0]   slot_q [2][NUM_BANDS];
  logic [OUT_W-1:0]   slot_d [2][NUM_BANDS];
  logic [FRAME_W-1:0] tag_q [2];
  logic [FRAME_W-1:0] tag_d [2];
  logic [OUT_W-1:0]   scaled [NUM_BANDS];

  logic [1:0]         full_q, full_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [FRAME_W-1:0] tag_cnt_q, tag_cnt_d;
  logic [3:0]         band_idx_q, band_idx_d;
  logic [0:0]         state_q, state_d;
  logic               overrun_q, overrun_d;
  logic [FRAME_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [3:0]         out_band_q, out_band_d;
  logic [FRAME_W-1:0] out_frame_q, out_frame_d;
  logic               out_last_q, out_last_d;
  logic               out_valid_q, out_valid_d;

  logic               xfer, release_slot;

  function automatic logic [OUT_W-1:0] scale_band(input logic [IN_W-1:0] x);
    logic signed [IN_W:0] sum;
    sum = $signed({x[IN_W-1], x}) + RND;
    sum = sum >>> SHIFT;
    if (sum > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (sum < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else                    return sum[OUT_W-1:0];
  endfunction

  // Round and saturate every band of the incoming frame.
  always_comb begin
    for (int unsigned k = 0; k < NUM_BANDS; k++) begin
      scaled[k] = scale_band(band_in[k*IN_W +: IN_W]);
    end
  end

  // Buffer bookkeeping, capture/drop handling and output-side sequencing.
  // Output registers are loaded from the post-edge read position, so they
  // stay put during a stall and advance with no bubble between frames.
  always_comb begin
    slot_d      = slot_q;
    tag_d       = tag_q;
    full_d      = full_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tag_cnt_d   = tag_cnt_q;
    band_idx_d  = band_idx_q;
    state_d     = state_q;
    overrun_d   = overrun_q;
    drop_cnt_d  = drop_cnt_q;

    xfer         = (state_q == ST_STREAM) && out_if.out_ready;
    release_slot = xfer && (band_idx_q == LAST_BAND);

    if (release_slot) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
      band_idx_d       = '0;
      state_d          = full_q[~rd_ptr_q] ? ST_STREAM : ST_EMPTY;
    end else if (xfer) begin
      band_idx_d = band_idx_q + 4'd1;
    end else if (state_q == ST_EMPTY && (full_q != 2'b00)) begin
      state_d = ST_STREAM;
    end

    if (overrun_clr) begin
      overrun_d  = 1'b0;
      drop_cnt_d = '0;
    end

    if (capture_strobe) begin
      // A slot being released on this edge is free for the new frame.
      if (!full_q[wr_ptr_q] || (release_slot && (wr_ptr_q == rd_ptr_q))) begin
        slot_d[wr_ptr_q] = scaled;
        tag_d[wr_ptr_q]  = tag_cnt_q;
        full_d[wr_ptr_q] = 1'b1;
        wr_ptr_d         = ~wr_ptr_q;
        tag_cnt_d        = tag_cnt_q + 1'b1;
      end else begin
        overrun_d = 1'b1;
        if (drop_cnt_d != '1) drop_cnt_d = drop_cnt_d + 1'b1;
      end
    end

    out_valid_d = (state_d == ST_STREAM);
    out_data_d  = '0;
    out_band_d  = '0;
    out_frame_d = '0;
    out_last_d  = 1'b0;
    if (state_d == ST_STREAM) begin
      out_data_d  = slot_q[rd_ptr_d][band_idx_d];
      out_band_d  = band_idx_d;
      out_frame_d = tag_q[rd_ptr_d];
      out_last_d  = (band_idx_d == LAST_BAND);
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_en) begin
    if (reset) begin
      full_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      tag_cnt_q   <= '0;
      band_idx_q  <= '0;
      state_q     <= ST_EMPTY;
      overrun_q   <= 1'b0;
      drop_cnt_q  <= '0;
      out_data_q  <= '0;
      out_band_q  <= '0;
      out_frame_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tag_cnt_q   <= tag_cnt_d;
      band_idx_q  <= band_idx_d;
      state_q     <= state_d;
      overrun_q   <= overrun_d;
      drop_cnt_q  <= drop_cnt_d;
      out_data_q  <= out_data_d;
      out_band_q  <= out_band_d;
      out_frame_q <= out_frame_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Slot payload and tags; validity is tracked by full_q, so no reset needed.
  always_ff @(posedge clk_en) begin
    slot_q <= slot_d;
    tag_q  <= tag_d;
  end

  assign out_if.out_data  = out_data_q;
  assign out_if.out_band  = out_band_q;
  assign out_if.out_frame = out_frame_q;
  assign out_if.out_last  = out_last_q;
  assign out_if.out_valid = out_valid_q;
  assign overrun          = overrun_q;
  assign drop_cnt         = drop_cnt_q;

endmodule

// File: doc/subband_frame_serializer.md
Name: subband_frame_serializer

Overview:
- Sits directly downstream of the 16-band filterbank.
- Captures all 16 parallel subband outputs on each decimation strobe (phase_49), then rounds and saturates each band to OUT_W bits.
- Streams the bands out one per transfer over a valid/ready interface, so a narrow consumer (FIFO, DMA, UART packer) can drain frames.
- A two-slot ping-pong buffer absorbs consumer backpressure; any further excess is dropped and counted.

Parameters:
NUM_BANDS, 16, number of subbands per frame
IN_W, 25, signed width of each filterbank output
OUT_W, 16, signed width of each emitted sample
SHIFT, 9, arithmetic right shift applied before saturation (0 = no rounding)
FRAME_W, 8, width of frame tag and drop counter

Ports:
clk_en  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high
capture_strobe  input  1  frame-ready strobe (filterbank phase_49), one cycle wide
band_in  input  NUM_BANDS*IN_W  packed subband outputs, band k at [k*IN_W +: IN_W]
out_data  output  OUT_W  scaled sample of current band
out_band  output  4  band index of out_data (0..NUM_BANDS-1)
out_frame  output  FRAME_W  tag of the frame being emitted
out_last  output  1  high with band NUM_BANDS-1
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts when high with out_valid
overrun  output  1  sticky: at least one frame dropped
overrun_clr  input  1  clears overrun and drop_cnt
drop_cnt  output  FRAME_W  saturating count of dropped frames

Behaviour:
- Reset is synchronous, active-high, clocked by clk_en.
  - Reset values: out_valid=0, out_data=0, out_band=0, out_frame=0, out_last=0, overrun=0, drop_cnt=0.
  - Internal state cleared: both slots empty, write/read pointers 0, capture tag counter 0, band index 0.
  - Reset mid-frame discards all buffered data; the partial frame is never completed.
- Scaling, per band, at capture time:
  - y = (x + 2^(SHIFT-1)) >>> SHIFT, computed at IN_W+1 bits (round half up).
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - SHIFT=0: no rounding term, saturation only.
- Capture:
  - Triggered on an edge where capture_strobe=1.
  - If a slot is free: write all NUM_BANDS scaled samples to slot[wr_ptr], tag it with the capture tag counter, toggle wr_ptr, increment the tag counter (wraps mod 2^FRAME_W).
  - If both slots are full: frame dropped; overrun<=1; drop_cnt increments and saturates at all-ones. The tag counter does not advance.
- Output side, states EMPTY / STREAM:
  - EMPTY: out_valid=0. Go to STREAM the cycle after any slot is filled. A capture at edge N gives out_valid=1 with band 0 from cycle N+1 (latency 1).
  - STREAM: out_valid=1 and out_data=slot[rd_ptr][band_idx]; out_band=band_idx; out_frame=slot tag; out_last=(band_idx==NUM_BANDS-1).
  - Outputs are registered and held stable while out_valid=1 and out_ready=0.
  - Transfer: out_valid & out_ready at an edge.
    - Non-last band: band_idx+1.
    - Last band: slot released, rd_ptr toggles, band_idx=0. Next state is STREAM if the other slot is full, else EMPTY.
  - Back-to-back frames have no bubble.
- Simultaneous events:
  - Capture with both slots full in the same edge as the last-band transfer: the capture is accepted into the slot being released. No drop, no overrun.
  - Capture into an empty buffer in the same edge: out_valid rises next cycle.
  - overrun_clr and a drop in the same edge: the drop wins (overrun=1, drop_cnt=1).
- capture_strobe held high for multiple cycles counts as one capture per edge. The filterbank guarantees 1-in-49.

Test Plan:
- Reset, then strobe with band k = k*512, out_ready=1 -> cycles 1..16 emit out_data=0..15, out_band=0..15, out_last only on band 15, out_frame=0, then out_valid=0.
- Rounding/saturation, SHIFT=9, bands = {255, 256, -256, -257, 16777215, -16777216} -> out_data {0, 1, 0, -1, 32767, -32768}.
- out_ready=0, three strobes 49 cycles apart -> frames tagged 0 and 1 buffered; third dropped; overrun=1, drop_cnt=1. Release ready -> 32 samples, tags 0 then 1, no gap.
- Both slots full, strobe coincident with frame-0 band-15 transfer -> no drop; next streamed frames are tags 1 then 2; overrun stays 0.
- out_ready toggled 1/0 every cycle -> out_data/out_band held stable while stalled; all 16 bands emitted in order, none duplicated.
- Assert reset at band 7 of a frame with the second slot full -> next cycle out_valid=0, drop_cnt=0. A new strobe yields out_frame=0 starting at band 0.
